// File: rtl/if_stage.sv
// Fetch stage: PC register, next-PC selection, instruction-memory request and IF/ID register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        pc_src_i,
    input  logic        if_flush_i,
    input  logic        jump_i,
    input  logic        jump_r_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] jr_target_i,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ifid_instr;
    logic [XLEN-1:0] r_ifid_pc4;
    logic            r_ifid_valid;

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_jump_target;
    logic [XLEN-1:0] w_jr_target;
    logic [XLEN-1:0] w_target;
    logic            w_redirect;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_ifid_we;
    logic [XLEN-1:0] w_instr_nxt;
    logic [XLEN-1:0] w_pc4_nxt;
    logic            w_valid_nxt;

    assign w_pc4         = r_pc + XLEN'(4);
    assign w_jump_target = {r_ifid_pc4[31:28], r_ifid_instr[25:0], 2'b00};
    assign w_jr_target   = jr_target_i & ~XLEN'(3);
    assign w_redirect    = pc_src_i | jump_i | jump_r_i;

    // Register-indirect jumps take precedence over direct jumps, which beat branches
    always_comb begin
        w_target = branch_target_i;
        if (jump_r_i) begin
            w_target = w_jr_target;
        end else if (jump_i) begin
            w_target = w_jump_target;
        end
    end

    // Next PC and IF/ID load; a stall freezes everything and drops redirects until ID re-asserts
    always_comb begin
        w_pc_nxt    = r_pc;
        w_ifid_we   = 1'b0;
        w_instr_nxt = NOP_INSTR;
        w_pc4_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (!stall_i) begin
            w_ifid_we = 1'b1;
            if (w_redirect) begin
                w_pc_nxt = w_target;
                if (!if_flush_i && imem_ready) begin
                    w_instr_nxt = imem_rdata;
                    w_pc4_nxt   = w_pc4;
                    w_valid_nxt = 1'b1;
                end
            end else if (if_flush_i) begin
                w_pc_nxt = w_pc4;
            end else if (imem_ready) begin
                w_pc_nxt    = w_pc4;
                w_instr_nxt = imem_rdata;
                w_pc4_nxt   = w_pc4;
                w_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if (w_ifid_we) begin
                r_ifid_instr <= w_instr_nxt;
                r_ifid_pc4   <= w_pc4_nxt;
                r_ifid_valid <= w_valid_nxt;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] r_fetch_cnt;
    logic [XLEN-1:0] r_bubble_cnt;

    // Every non-stall edge loads IF/ID with either a real instruction or a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (w_ifid_we) begin
            if (w_valid_nxt) begin
                r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
            end else begin
                r_bubble_cnt <= r_bubble_cnt + XLEN'(1);
            end
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

    assign imem_addr    = r_pc;
    assign ifid_instr_o = r_ifid_instr;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_valid_o = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table feeding a scoreboard queue, plus reset sequences.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        pc_src_i;
    logic        if_flush_i;
    logic        jump_i;
    logic        jump_r_i;
    logic [31:0] branch_target_i;
    logic [31:0] jr_target_i;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] imem_addr;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    if_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .pc_src_i        (pc_src_i),
        .if_flush_i      (if_flush_i),
        .jump_i          (jump_i),
        .jump_r_i        (jump_r_i),
        .branch_target_i (branch_target_i),
        .jr_target_i     (jr_target_i),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .imem_addr       (imem_addr),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_valid_o    (ifid_valid_o)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o     (fetch_cnt_o),
        .bubble_cnt_o    (bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        pc_src;
        logic        flush;
        logic        jump;
        logic        jump_r;
        logic        ready;
        logic [31:0] bt;
        logic [31:0] jrt;
        logic [31:0] rdata;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   exp_fetch  = 0;
    int   exp_bubble = 0;

    function automatic vec_t mk(input logic st, input logic ps, input logic fl,
                                input logic jp, input logic jr, input logic rdy,
                                input logic [31:0] bt, input logic [31:0] jrt,
                                input logic [31:0] rd, input logic [31:0] epc,
                                input logic [31:0] ein, input logic [31:0] ep4,
                                input logic ev);
        vec_t v;
        v.stall = st; v.pc_src = ps; v.flush = fl; v.jump = jp; v.jump_r = jr;
        v.ready = rdy; v.bt = bt; v.jrt = jrt; v.rdata = rd;
        v.e_pc = epc; v.e_instr = ein; v.e_pc4 = ep4; v.e_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall_i = 0; pc_src_i = 0; if_flush_i = 0; jump_i = 0; jump_r_i = 0;
        branch_target_i = '0; jr_target_i = '0; imem_rdata = '0; imem_ready = 0;
    endtask

    // Drive one vector on the falling edge, queue its expectation, compare after the rising edge
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t got;
        @(negedge clk);
        stall_i = v.stall; pc_src_i = v.pc_src; if_flush_i = v.flush;
        jump_i = v.jump; jump_r_i = v.jump_r; imem_ready = v.ready;
        branch_target_i = v.bt; jr_target_i = v.jrt; imem_rdata = v.rdata;
        e.name = name; e.pc = v.e_pc; e.instr = v.e_instr; e.pc4 = v.e_pc4; e.valid = v.e_valid;
        sb.push_back(e);
        if (!v.stall) begin
            if (v.e_valid) exp_fetch++;
            else exp_bubble++;
        end
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({got.name, ".pc"},    imem_addr,           got.pc);
        chk({got.name, ".instr"}, ifid_instr_o,        got.instr);
        chk({got.name, ".pc4"},   ifid_pc4_o,          got.pc4);
        chk({got.name, ".valid"}, 32'(ifid_valid_o),   32'(got.valid));
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, ".pc"},    imem_addr,         32'h0);
        chk({name, ".instr"}, ifid_instr_o,      32'h0);
        chk({name, ".pc4"},   ifid_pc4_o,        32'h0);
        chk({name, ".valid"}, 32'(ifid_valid_o), 32'h0);
`ifdef IF_PERF_CNT_EN
        chk({name, ".fetch_cnt"},  fetch_cnt_o,  32'h0);
        chk({name, ".bubble_cnt"}, bubble_cnt_o, 32'h0);
`endif
    endtask

    initial begin
        // fields: stall pc_src flush jump jump_r ready | bt jrt rdata | exp pc instr pc4 valid
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h1111_1111, 32'h4, 32'h1111_1111, 32'h4, 1));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h2222_2222, 32'h8, 32'h2222_2222, 32'h8, 1));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h0C00_0040, 32'hC, 32'h0C00_0040, 32'hC, 1));
        vecs.push_back(mk(0,1,1,0,1,1, 32'h500, 32'h8000_000F, 32'h3333_3333, 32'h8000_000C, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h0C00_0040, 32'h8000_0010, 32'h0C00_0040, 32'h8000_0010, 1));
        vecs.push_back(mk(0,0,0,1,0,1, 32'h0, 32'h0, 32'h4444_4444, 32'h8000_0100, 32'h4444_4444, 32'h8000_0014, 1));
        vecs.push_back(mk(0,1,0,0,1,1, 32'h700, 32'h203, 32'h5555_5555, 32'h200, 32'h5555_5555, 32'h8000_0104, 1));
        vecs.push_back(mk(0,1,1,0,0,1, 32'h40, 32'h0, 32'h0, 32'h40, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,1,1,0,0,1, 32'h100, 32'h0, 32'h6666_6666, 32'h100, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h7777_7777, 32'h104, 32'h7777_7777, 32'h104, 1));
        vecs.push_back(mk(1,1,1,0,0,1, 32'h300, 32'h0, 32'hDEAD_BEEF, 32'h104, 32'h7777_7777, 32'h104, 1));
        vecs.push_back(mk(1,1,1,0,0,1, 32'h300, 32'h0, 32'hDEAD_BEEF, 32'h104, 32'h7777_7777, 32'h104, 1));
        vecs.push_back(mk(0,1,1,0,0,1, 32'h300, 32'h0, 32'hDEAD_BEEF, 32'h300, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,1,0,0,1, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h304, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,1,1,0,0,1, 32'h20, 32'h0, 32'h0, 32'h20, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 32'h1234_5678, 32'h20, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,0,0,0,0, 32'h0, 32'h0, 32'h1234_5678, 32'h20, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h8888_8888, 32'h24, 32'h8888_8888, 32'h24, 1));
        vecs.push_back(mk(0,1,0,0,0,0, 32'h600, 32'h0, 32'h0, 32'h600, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,1,0,1,1, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'h9999_9999, 32'h0, 32'h9999_9999, 32'h0, 1));
        vecs.push_back(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'hAAAA_AAAA, 32'h4, 32'hAAAA_AAAA, 32'h4, 1));

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt",  fetch_cnt_o,  32'(exp_fetch));
        chk("bubble_cnt", bubble_cnt_o, 32'(exp_bubble));
`endif

        // Asynchronous reset mid-run: state must clear before any clock edge
        @(negedge clk);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_fetch = 0;
        exp_bubble = 0;
        apply(mk(0,0,0,0,0,1, 32'h0, 32'h0, 32'hBBBB_BBBB, 32'h4, 32'hBBBB_BBBB, 32'h4, 1), "post_reset");
`ifdef IF_PERF_CNT_EN
        chk("post_reset.fetch_cnt",  fetch_cnt_o,  32'(exp_fetch));
        chk("post_reset.bubble_cnt", bubble_cnt_o, 32'(exp_bubble));
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
